// File: rtl/hella_cache_pkg.sv
// Shared command/size encodings and helpers for the hella-cache slave memory model.
package hella_cache_pkg;

  localparam logic [4:0] M_XRD     = 5'b00000;
  localparam logic [4:0] M_XWR     = 5'b00001;
  localparam logic [4:0] M_AMOSWAP = 5'b00100;
  localparam logic [4:0] M_AMOADD  = 5'b01000;

  // typ[1:0] = size, typ[2] = unsigned
  localparam logic [2:0] MT_B  = 3'b000;
  localparam logic [2:0] MT_H  = 3'b001;
  localparam logic [2:0] MT_W  = 3'b010;
  localparam logic [2:0] MT_D  = 3'b011;
  localparam logic [2:0] MT_BU = 3'b100;
  localparam logic [2:0] MT_HU = 3'b101;
  localparam logic [2:0] MT_WU = 3'b110;

  function automatic logic is_amo(input logic [4:0] cmd);
    return (cmd == M_AMOSWAP) || (cmd == M_AMOADD);
  endfunction

  function automatic logic is_legal(input logic [4:0] cmd);
    return (cmd == M_XRD) || (cmd == M_XWR) || is_amo(cmd);
  endfunction

  function automatic logic is_misaligned(input logic [2:0] typ, input logic [2:0] off);
    case (typ[1:0])
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      2'd3:    return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hella_cache_load_gen.sv
// Extracts the addressed B/H/W/D field from a 64-bit word and sign/zero-extends it.
module hella_cache_load_gen
  import hella_cache_pkg::*;
(
  input  logic [2:0]  i_typ,
  input  logic [2:0]  i_off,
  input  logic [63:0] i_word,
  output logic [63:0] o_data
);

  logic [63:0] w_sh;
  logic        w_sgn;

  assign w_sh  = i_word >> {i_off, 3'b000};
  assign w_sgn = ~i_typ[2];

  always_comb begin
    o_data = w_sh;
    case (i_typ[1:0])
      2'd0:    o_data = {{56{w_sgn & w_sh[7]}},  w_sh[7:0]};
      2'd1:    o_data = {{48{w_sgn & w_sh[15]}}, w_sh[15:0]};
      2'd2:    o_data = {{32{w_sgn & w_sh[31]}}, w_sh[31:0]};
      default: o_data = w_sh;
    endcase
  end

endmodule

// File: rtl/hella_cache_slave_mem.sv
// Behavioural hella-cache responder: s0 accept, s1 data/kill/commit, s2 response or nack.
module hella_cache_slave_mem
  import hella_cache_pkg::*;
#(
  parameter int NUM_ADDR_BITS = 40,
  parameter int NUM_DATA_BITS = 64,
  parameter int NUM_TAG_BITS  = 7,
  parameter int MEM_WORD_BITS = 12,
  parameter int NACK_PERIOD   = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [NUM_ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_TAG_BITS-1:0]    req_tag,
  input  logic [4:0]                 req_cmd,
  input  logic [2:0]                 req_typ,
  input  logic [NUM_DATA_BITS-1:0]   req_data,
  input  logic [NUM_DATA_BITS/8-1:0] req_data_mask,
  input  logic                       req_kill,
  output logic                       rsp_nack,
  output logic                       rsp_valid,
  output logic [NUM_TAG_BITS-1:0]    rsp_tag,
  output logic [2:0]                 rsp_typ,
  output logic [NUM_DATA_BITS-1:0]   rsp_data,
  output logic                       rsp_has_data,
  output logic                       ordered
);

  localparam int CW = (NACK_PERIOD > 1) ? $clog2(NACK_PERIOD) : 1;
  localparam int NB = NUM_DATA_BITS / 8;

  logic [NUM_DATA_BITS-1:0] r_mem [0:(1<<MEM_WORD_BITS)-1];

  logic                     r_ready;
  logic [CW-1:0]            r_cnt;
  logic [2:1]               r_vld_pipe;
  logic [MEM_WORD_BITS-1:0] r_s1_idx;
  logic [2:0]               r_s1_off;
  logic [NUM_TAG_BITS-1:0]  r_s1_tag;
  logic [4:0]               r_s1_cmd;
  logic [2:0]               r_s1_typ;
  logic                     r_s1_nack;
  logic                     r_rsp_valid, r_rsp_nack, r_rsp_has_data;
  logic [NUM_TAG_BITS-1:0]  r_rsp_tag;
  logic [2:0]               r_rsp_typ;
  logic [NUM_DATA_BITS-1:0] r_rsp_data;

  logic                     w_acc, w_cnt_hit, w_s0_nack;
  logic                     w_live, w_commit, w_has_data;
  logic [NUM_DATA_BITS-1:0] w_old, w_new, w_bmask, w_wdata, w_fmt;
  logic                     w_unused;

  assign w_unused  = &{1'b0, req_addr[NUM_ADDR_BITS-1:MEM_WORD_BITS+3]};

  assign w_acc     = req_valid && r_ready;
  assign w_cnt_hit = (NACK_PERIOD != 0) && (r_cnt == CW'(NACK_PERIOD - 1));
  assign w_s0_nack = w_cnt_hit || !is_legal(req_cmd) || is_misaligned(req_typ, req_addr[2:0]);

  // s1 stage: kill and commit are resolved against the live req_* inputs
  assign w_old      = r_mem[r_s1_idx];
  assign w_live     = r_vld_pipe[1] && !req_kill;
  assign w_commit   = w_live && !r_s1_nack;
  assign w_has_data = (r_s1_cmd != M_XWR);

  always_comb begin
    w_new = req_data;
    if (r_s1_cmd == M_AMOADD) begin
      if (r_s1_typ[1:0] == MT_W[1:0]) begin
        w_new = w_old;
        if (r_s1_off[2]) w_new[63:32] = w_old[63:32] + req_data[63:32];
        else             w_new[31:0]  = w_old[31:0]  + req_data[31:0];
      end else begin
        w_new = w_old + req_data;
      end
    end
    for (int i = 0; i < NB; i++) w_bmask[i*8 +: 8] = {8{req_data_mask[i]}};
    w_wdata = (w_new & w_bmask) | (w_old & ~w_bmask);
  end

  hella_cache_load_gen u_load_gen (
    .i_typ  (r_s1_typ),
    .i_off  (r_s1_off),
    .i_word (w_old),
    .o_data (w_fmt)
  );

  always_ff @(posedge clock) begin
    if (w_commit && r_s1_cmd != M_XRD) r_mem[r_s1_idx] <= w_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ready        <= 1'b0;
      r_cnt          <= '0;
      r_vld_pipe     <= '0;
      r_s1_idx       <= '0;
      r_s1_off       <= '0;
      r_s1_tag       <= '0;
      r_s1_cmd       <= '0;
      r_s1_typ       <= '0;
      r_s1_nack      <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_rsp_nack     <= 1'b0;
      r_rsp_has_data <= 1'b0;
      r_rsp_tag      <= '0;
      r_rsp_typ      <= '0;
      r_rsp_data     <= '0;
    end else begin
      r_ready       <= 1'b1;
      r_vld_pipe[1] <= w_acc;
      r_vld_pipe[2] <= w_live;
      if (w_acc) begin
        r_cnt     <= w_cnt_hit ? '0 : r_cnt + 1'b1;
        r_s1_idx  <= req_addr[MEM_WORD_BITS+2:3];
        r_s1_off  <= req_addr[2:0];
        r_s1_tag  <= req_tag;
        r_s1_cmd  <= req_cmd;
        r_s1_typ  <= req_typ;
        r_s1_nack <= w_s0_nack;
      end
      r_rsp_valid    <= w_commit;
      r_rsp_nack     <= w_live && r_s1_nack;
      r_rsp_has_data <= w_commit && w_has_data;
      r_rsp_data     <= (w_commit && w_has_data) ? w_fmt : '0;
      if (w_live) begin
        r_rsp_tag <= r_s1_tag;
        r_rsp_typ <= r_s1_typ;
      end
    end
  end

  assign req_ready    = r_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_nack     = r_rsp_nack;
  assign rsp_tag      = r_rsp_tag;
  assign rsp_typ      = r_rsp_typ;
  assign rsp_data     = r_rsp_data;
  assign rsp_has_data = r_rsp_has_data;
  assign ordered      = !(r_vld_pipe[1] || r_vld_pipe[2]);

endmodule
